// File: rtl/l4_frame_builder.sv
// l4_frame_builder: builds Ethernet/[VLAN]/IPv4/UDP frames one byte per beat from a header command plus payload stream.
// Optional 802.1Q tag insertion is compiled in with `define L4_FRAME_VLAN_EN.
module l4_frame_builder #(
  parameter logic [7:0] TTL       = 8'h40,
  parameter int         MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [47:0] cmd_dst_mac,
  input  logic [47:0] cmd_src_mac,
  input  logic [31:0] cmd_src_ip,
  input  logic [31:0] cmd_dst_ip,
  input  logic [15:0] cmd_src_port,
  input  logic [15:0] cmd_dst_port,
  input  logic [15:0] cmd_pl_len,
`ifdef L4_FRAME_VLAN_EN
  input  logic        cmd_vlan_en,
  input  logic [15:0] cmd_vlan_tci,
`endif
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof
);

  localparam logic [15:0] VLAN = 16'h8100;
  localparam logic [15:0] IPV4 = 16'h0800;
  localparam logic [7:0]  UDP  = 8'd17;

  typedef enum logic [3:0] {
    st_idle, st_csum, st_destmac, st_srcmac, st_vlan, st_arbt,
    st_ipv4, st_udp, st_l4_payload, st_pad, st_end
  } type_state_e;

  type_state_e state, state_nxt;
  logic [15:0] cnt, fcnt, frame_len, frame_id, csum;
  logic [19:0] acc;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, pl_len;
  logic        vlan_en, vlan_cmd;
  logic [15:0] vlan_tci;
  logic        accept, load, emit, last;
  logic [7:0]  byte_nxt;
  logic [15:0] total_len, udp_len, csum_word, hdr_plus, frame_len_new;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;
  logic [7:0]   dst_byte, src_byte, vlan_byte, eth_byte, ip_byte, udp_byte;

`ifdef L4_FRAME_VLAN_EN
  assign vlan_cmd = cmd_vlan_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vlan_en  <= 1'b0;
      vlan_tci <= 16'h0000;
    end else if (accept) begin
      vlan_en  <= cmd_vlan_en;
      vlan_tci <= cmd_vlan_tci;
    end
  end
`else
  assign vlan_cmd = 1'b0;
  assign vlan_en  = 1'b0;
  assign vlan_tci = 16'h0000;
`endif

  assign cmd_ready = (state == st_idle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign load      = !tx_valid || tx_ready;
  assign pl_ready  = (state == st_l4_payload) && load;
  assign last      = (fcnt == frame_len - 16'd1);

  assign total_len     = pl_len + 16'd28;
  assign udp_len       = pl_len + 16'd8;
  assign hdr_plus      = cmd_pl_len + (vlan_cmd ? 16'd46 : 16'd42);
  assign frame_len_new = (hdr_plus < 16'(MIN_FRAME)) ? 16'(MIN_FRAME) : hdr_plus;

  always_comb begin
    csum_word = 16'h0000;
    case (cnt[3:0])
      4'd0: csum_word = 16'h4500;
      4'd1: csum_word = total_len;
      4'd2: csum_word = frame_id;
      4'd3: csum_word = 16'h4000;
      4'd4: csum_word = {TTL, UDP};
      4'd6: csum_word = src_ip[31:16];
      4'd7: csum_word = src_ip[15:0];
      4'd8: csum_word = dst_ip[31:16];
      4'd9: csum_word = dst_ip[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Two folds are enough: after the first the carry is at most one.
  assign fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  assign ip_hdr  = {16'h4500, total_len, frame_id, 16'h4000, TTL, UDP, csum, src_ip, dst_ip};
  assign udp_hdr = {src_port, dst_port, udp_len, 16'h0000};

  assign dst_byte  = 8'(dst_mac >> {3'd5 - cnt[2:0], 3'b000});
  assign src_byte  = 8'(src_mac >> {3'd5 - cnt[2:0], 3'b000});
  assign vlan_byte = 8'({VLAN, vlan_tci} >> {2'd3 - cnt[1:0], 3'b000});
  assign eth_byte  = cnt[0] ? IPV4[7:0] : IPV4[15:8];
  assign ip_byte   = 8'(ip_hdr >> {5'd19 - cnt[4:0], 3'b000});
  assign udp_byte  = 8'(udp_hdr >> {3'd7 - cnt[2:0], 3'b000});

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    byte_nxt  = 8'h00;
    case (state)
      st_idle: if (accept) state_nxt = st_csum;
      st_csum: if (cnt == 16'd10) state_nxt = st_destmac;
      st_destmac: begin
        emit = load; byte_nxt = dst_byte;
        if (emit && cnt == 16'd5) state_nxt = st_srcmac;
      end
      st_srcmac: begin
        emit = load; byte_nxt = src_byte;
        if (emit && cnt == 16'd5) state_nxt = vlan_en ? st_vlan : st_arbt;
      end
      st_vlan: begin
        emit = load; byte_nxt = vlan_byte;
        if (emit && cnt == 16'd3) state_nxt = st_arbt;
      end
      st_arbt: begin
        emit = load; byte_nxt = eth_byte;
        if (emit && cnt == 16'd1) state_nxt = st_ipv4;
      end
      st_ipv4: begin
        emit = load; byte_nxt = ip_byte;
        if (emit && cnt == 16'd19) state_nxt = st_udp;
      end
      st_udp: begin
        emit = load; byte_nxt = udp_byte;
        if (emit && cnt == 16'd7) state_nxt = (pl_len == 16'd0) ? st_pad : st_l4_payload;
      end
      st_l4_payload: begin
        emit = load && pl_valid; byte_nxt = pl_data;
        if (emit && cnt == pl_len - 16'd1) state_nxt = last ? st_end : st_pad;
      end
      st_pad: begin
        emit = load;
        if (emit && last) state_nxt = st_end;
      end
      st_end: if (tx_valid && tx_ready) state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_idle;
      cnt <= '0; fcnt <= '0; frame_len <= '0; frame_id <= '0; csum <= '0; acc <= '0;
      dst_mac <= '0; src_mac <= '0; src_ip <= '0; dst_ip <= '0;
      src_port <= '0; dst_port <= '0; pl_len <= '0;
      tx_valid <= 1'b0; tx_data <= 8'h00; tx_sof <= 1'b0; tx_eof <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (state == st_csum || emit) cnt <= cnt + 16'd1;
      if (accept) begin
        dst_mac <= cmd_dst_mac; src_mac <= cmd_src_mac;
        src_ip <= cmd_src_ip; dst_ip <= cmd_dst_ip;
        src_port <= cmd_src_port; dst_port <= cmd_dst_port;
        pl_len <= cmd_pl_len; frame_len <= frame_len_new;
        acc <= '0; fcnt <= '0;
      end
      if (state == st_csum) begin
        if (cnt < 16'd10) acc <= acc + {4'b0, csum_word};
        else csum <= ~fold2;
      end
      if (emit) fcnt <= fcnt + 16'd1;
      if (load) begin
        tx_valid <= emit;
        if (emit) begin
          tx_data <= byte_nxt;
          tx_sof  <= (fcnt == 16'd0);
          tx_eof  <= last;
        end
      end
      if (state == st_end && tx_valid && tx_ready) frame_id <= frame_id + 16'd1;
    end
  end

endmodule

// File: tb/tb_l4_frame_builder.sv
// Directed bench for l4_frame_builder: reference vectors, padding, backpressure, ID wrap and mid-frame reset.
module tb_l4_frame_builder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [47:0] cmd_dst_mac = 48'h0211_2233_4455, cmd_src_mac = 48'h02AA_BBCC_DDEE;
  logic [31:0] cmd_src_ip = '0, cmd_dst_ip = '0;
  logic [15:0] cmd_src_port = 16'h1234, cmd_dst_port = 16'h5678, cmd_pl_len = '0;
`ifdef L4_FRAME_VLAN_EN
  logic        cmd_vlan_en = 1'b0;
  logic [15:0] cmd_vlan_tci = 16'h0000;
`endif
  logic [7:0]  pl_data = 8'h00, tx_data;
  logic        pl_valid = 1'b1, pl_ready, tx_valid, tx_ready = 1'b1, tx_sof, tx_eof;

  always #5 clk = ~clk;

  l4_frame_builder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_mac(cmd_dst_mac), .cmd_src_mac(cmd_src_mac), .cmd_src_ip(cmd_src_ip),
    .cmd_dst_ip(cmd_dst_ip), .cmd_src_port(cmd_src_port), .cmd_dst_port(cmd_dst_port),
    .cmd_pl_len(cmd_pl_len),
`ifdef L4_FRAME_VLAN_EN
    .cmd_vlan_en(cmd_vlan_en), .cmd_vlan_tci(cmd_vlan_tci),
`endif
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof), .tx_eof(tx_eof)
  );

  int n_cmp = 0, n_bad = 0;
  logic [7:0] pay [2048];
  int pi = 0, drop_at = -1, drop_left = 0, lat = 0;
  bit bp_mode = 1'b0, take = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic [7:0] fb [10][1600];
  bit fsof [10][1600];
  int flen [10];
  int nf = 0, mc = 0;

  typedef struct { int frm; int pos; logic [7:0] exp; } vec_t;
  vec_t vt [40];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Payload source, tx_ready pattern and tx capture; samples on the falling edge, drives just after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      take = 1'b0;
      if (rst) begin
        mc = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, prev_dat});
        prev_stall = tx_valid && !tx_ready;
        prev_dat = tx_data;
        if (tx_valid && tx_ready) begin
          if (nf < 10 && mc < 1600) begin fb[nf][mc] = tx_data; fsof[nf][mc] = tx_sof; end
          mc++;
          if (tx_eof) begin
            if (nf < 10) flen[nf] = mc;
            nf++; mc = 0;
          end
        end
        take = pl_valid && pl_ready;
      end
      @(posedge clk); #1;
      if (take) pi++;
      if (drop_at == pi && drop_left > 0) begin pl_valid = 1'b0; drop_left--; end
      else pl_valid = 1'b1;
      pl_data = pay[pi % 2048];
      tx_ready = bp_mode ? ~tx_ready : 1'b1;
    end
  end

  task automatic send(input logic [15:0] len, input logic [31:0] sip, input logic [31:0] dip,
                      input logic [7:0] seed, input bit vlan, input logic [15:0] tci);
    int t = 0;
    @(negedge clk);
    pi = 0;
    for (int i = 0; i < 2048; i++) pay[i] = 8'(seed + i * 17);
    cmd_pl_len = len; cmd_src_ip = sip; cmd_dst_ip = dip;
`ifdef L4_FRAME_VLAN_EN
    cmd_vlan_en = vlan; cmd_vlan_tci = tci;
`else
    if (vlan || tci != 16'h0) $display("note: VLAN request ignored in untagged build");
`endif
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("cmd_accept_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("first_byte_latency", 32'(lat), 32'd12);
  endtask

  task automatic wait_frame(input int k);
    int t = 0;
    while (nf <= k && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) chk("frame_timeout", 32'(nf), 32'(k + 1));
  endtask

  task automatic check_frame(input int k, input string nm, input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] len, input logic [15:0] id, input bit vlan, input logic [15:0] tci);
    logic [7:0] e [1600];
    logic [15:0] w [10];
    logic [31:0] s;
    int n = 0, bad = -1, lim;
    bit sof_ok;
    for (int b = 5; b >= 0; b--) e[n++] = cmd_dst_mac[8*b +: 8];
    for (int b = 5; b >= 0; b--) e[n++] = cmd_src_mac[8*b +: 8];
    if (vlan) begin e[n++] = 8'h81; e[n++] = 8'h00; e[n++] = tci[15:8]; e[n++] = tci[7:0]; end
    e[n++] = 8'h08; e[n++] = 8'h00;
    w[0] = 16'h4500; w[1] = len + 16'd28; w[2] = id; w[3] = 16'h4000; w[4] = 16'h4011;
    w[5] = 16'h0000; w[6] = sip[31:16]; w[7] = sip[15:0]; w[8] = dip[31:16]; w[9] = dip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'h0, w[i]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    w[5] = ~s[15:0];
    for (int i = 0; i < 10; i++) begin e[n++] = w[i][15:8]; e[n++] = w[i][7:0]; end
    e[n++] = cmd_src_port[15:8]; e[n++] = cmd_src_port[7:0];
    e[n++] = cmd_dst_port[15:8]; e[n++] = cmd_dst_port[7:0];
    e[n++] = 8'((len + 16'd8) >> 8); e[n++] = 8'(len + 16'd8);
    e[n++] = 8'h00; e[n++] = 8'h00;
    for (int i = 0; i < int'(len); i++) e[n++] = pay[i];
    while (n < 60) e[n++] = 8'h00;
    chk({nm, "_len"}, 32'(flen[k]), 32'(n));
    lim = (flen[k] < n) ? flen[k] : n;
    if (lim > 1600) lim = 1600;
    for (int i = 0; i < lim; i++) if (bad < 0 && fb[k][i] !== e[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s byte %0d: got %h expected %h", nm, bad + 1, fb[k][bad], e[bad]);
    end
    sof_ok = fsof[k][0];
    for (int i = 1; i < lim; i++) if (fsof[k][i]) sof_ok = 1'b0;
    chk({nm, "_sof"}, {31'b0, sof_ok}, 32'd1);
  endtask

  initial begin
    logic [7:0] rip [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                             8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    logic [7:0] spl [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int t;
    for (int i = 0; i < 20; i++) vt[i] = '{0, 15 + i, rip[i]};
    vt[20] = '{0, 39, 8'h00};
    vt[21] = '{0, 40, 8'h5F};
    for (int i = 0; i < 4; i++) vt[22 + i] = '{1, 43 + i, spl[i]};
    for (int i = 0; i < 14; i++) vt[26 + i] = '{1, 47 + i, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_sof_eof", {30'b0, tx_sof, tx_eof}, 32'd0);
    chk("rst_pl_ready", {31'b0, pl_ready}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    send(16'd87, 32'hC0A8_0001, 32'hC0A8_00C7, 8'h10, 1'b0, 16'h0);
    wait_frame(0);
    chk("ref_consumed", 32'(pi), 32'd87);
    check_frame(0, "ref", 32'hC0A8_0001, 32'hC0A8_00C7, 16'd87, 16'h0000, 1'b0, 16'h0);

    send(16'd4, 32'h0A00_0001, 32'h0A00_0002, 8'hAA, 1'b0, 16'h0);
    wait_frame(1);
    chk("short_consumed", 32'(pi), 32'd4);
    check_frame(1, "short", 32'h0A00_0001, 32'h0A00_0002, 16'd4, 16'h0001, 1'b0, 16'h0);
    chk("ref_eof_pos", 32'(flen[0]), 32'd129);
    chk("short_eof_pos", 32'(flen[1]), 32'd60);
    for (int i = 0; i < 40; i++)
      chk($sformatf("vec%0d_f%0d_b%0d", i, vt[i].frm, vt[i].pos), {24'b0, fb[vt[i].frm][vt[i].pos - 1]}, {24'b0, vt[i].exp});

    send(16'd0, 32'h0A00_0003, 32'h0A00_0004, 8'h33, 1'b0, 16'h0);
    wait_frame(2);
    chk("zero_consumed", 32'(pi), 32'd0);
    check_frame(2, "zero", 32'h0A00_0003, 32'h0A00_0004, 16'd0, 16'h0002, 1'b0, 16'h0);

    @(negedge clk);
    bp_mode = 1'b1; drop_at = 10; drop_left = 5;
    send(16'd20, 32'h0A00_0005, 32'h0A00_0006, 8'h5C, 1'b0, 16'h0);
    wait_frame(3);
    bp_mode = 1'b0; drop_at = -1;
    chk("bp_consumed", 32'(pi), 32'd20);
    check_frame(3, "bp", 32'h0A00_0005, 32'h0A00_0006, 16'd20, 16'h0003, 1'b0, 16'h0);

    repeat (3) @(negedge clk);
    force dut.frame_id = 16'hFFFF;
    @(negedge clk);
    release dut.frame_id;
    send(16'd10, 32'hAC10_0001, 32'hAC10_0002, 8'h01, 1'b0, 16'h0);
    wait_frame(4);
    check_frame(4, "id_ffff", 32'hAC10_0001, 32'hAC10_0002, 16'd10, 16'hFFFF, 1'b0, 16'h0);
    send(16'd5, 32'hAC10_0001, 32'hAC10_0002, 8'h02, 1'b0, 16'h0);
    wait_frame(5);
    check_frame(5, "id_wrap", 32'hAC10_0001, 32'hAC10_0002, 16'd5, 16'h0000, 1'b0, 16'h0);

    send(16'd30, 32'h0A00_0007, 32'h0A00_0008, 8'h44, 1'b0, 16'h0);
    t = 0;
    while (pi < 10 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("reset_wait_timeout", 32'(pi), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("frames_after_rst", 32'(nf), 32'd6);
    send(16'd12, 32'h0A00_0009, 32'h0A00_000A, 8'h77, 1'b0, 16'h0);
    wait_frame(6);
    check_frame(6, "post_rst", 32'h0A00_0009, 32'h0A00_000A, 16'd12, 16'h0000, 1'b0, 16'h0);

`ifdef L4_FRAME_VLAN_EN
    send(16'd16, 32'h0A00_000B, 32'h0A00_000C, 8'h21, 1'b1, 16'h0064);
    wait_frame(7);
    check_frame(7, "vlan", 32'h0A00_000B, 32'h0A00_000C, 16'd16, 16'h0001, 1'b1, 16'h0064);
    chk("vlan_b13_16", {fb[7][12], fb[7][13], fb[7][14], fb[7][15]}, 32'h8100_0064);
    chk("vlan_b17_19", {8'h00, fb[7][16], fb[7][17], fb[7][18]}, 32'h0008_0045);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
